// File: rtl/stream_capture_buffer.sv
// rtl/stream_capture_buffer.sv - valid-qualified sample capture buffer with skip window and drain port (optional CAPTURE_OVF_CNT_EN)
module stream_capture_buffer #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 13,
    parameter int SKIP   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              capturing,
    output logic              full,
    output logic [15:0]       ovf_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_FULL
    } state_t;

    // Last skip index and last write address before the buffer is full
    localparam logic [15:0]     SKIP_LAST = 16'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [ADDR_W:0] WR_LAST   = (ADDR_W + 1)'(DEPTH - 1);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [15:0]       skip_cnt;
    logic              wr_accept;
    logic              rd_accept;

    // arm has priority: the arm cycle neither writes nor reads
    assign wr_accept = !arm && data_valid && (state == ST_CAPTURE);
    assign rd_accept = !arm && rd_en && (state != ST_IDLE) && (count != '0);

    // Pointers never wrap within one acquisition, so the difference is the fill level
    assign count     = wr_ptr - rd_ptr;
    assign capturing = (state == ST_CAPTURE);
    assign full      = (state == ST_FULL);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: arm restarts from any state, FULL holds until re-armed
    always_comb begin
        state_next = state;
        if (arm) begin
            state_next = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
        end else begin
            case (state)
                ST_SKIP: begin
                    if (data_valid && (skip_cnt == SKIP_LAST)) begin
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (wr_accept && (wr_ptr == WR_LAST)) begin
                        state_next = ST_FULL;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Write/read pointers and skip counter, all cleared by arm
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            skip_cnt <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            skip_cnt <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if ((state == ST_SKIP) && data_valid) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end

    // Sample storage, no reset so it maps onto block RAM
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= data;
        end
    end

    // Registered read port; rd_data holds its last value between reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

`ifdef CAPTURE_OVF_CNT_EN
    // Count samples arriving while full, saturating at all ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (arm) begin
            ovf_count <= '0;
        end else if ((state == ST_FULL) && data_valid && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end
`else
    assign ovf_count = 16'd0;
`endif

endmodule

// File: tb/tb_stream_capture_buffer.sv
// tb/tb_stream_capture_buffer.sv - directed self-checking bench for stream_capture_buffer
module tb_stream_capture_buffer;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic              data_valid = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              rd_en = 1'b0;

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              capturing;
    logic              full;
    logic [15:0]       ovf_count;

    logic [DATA_W-1:0] s3_rd_data;
    logic              s3_rd_valid;
    logic [ADDR_W:0]   s3_count;
    logic              s3_capturing;
    logic              s3_full;
    logic [15:0]       s3_ovf_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_ovf;

    always #5 clock = ~clock;

    stream_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP(0)) dut (
        .clock(clock), .reset(reset), .arm(arm), .data_valid(data_valid), .data(data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
        .capturing(capturing), .full(full), .ovf_count(ovf_count)
    );

    stream_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP(3)) dut_skip3 (
        .clock(clock), .reset(reset), .arm(arm), .data_valid(data_valid), .data(data),
        .rd_en(rd_en), .rd_data(s3_rd_data), .rd_valid(s3_rd_valid), .count(s3_count),
        .capturing(s3_capturing), .full(s3_full), .ovf_count(s3_ovf_count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    initial begin
`ifdef CAPTURE_OVF_CNT_EN
        exp_ovf = 16'd2;
`else
        exp_ovf = 16'd0;
`endif
        // reset state
        step();
        step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_capturing", 64'(capturing), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_ovf", 64'(ovf_count), 64'd0);
        reset = 1'b0;
        step();

        // arm, then read on empty buffer
        pulse_arm();
        check("arm_capturing", 64'(capturing), 64'd1);
        check("arm_skip3_capturing", 64'(s3_capturing), 64'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("empty_rd_valid", 64'(rd_valid), 64'd0);
        check("empty_count", 64'(count), 64'd0);

        // five samples 1..5 then drain
        data_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data = 64'(i);
            step();
        end
        data_valid = 1'b0;
        check("five_count", 64'(count), 64'd5);
        for (int i = 1; i <= 5; i++) begin
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            check($sformatf("drain_valid_%0d", i), 64'(rd_valid), 64'd1);
            check($sformatf("drain_data_%0d", i), rd_data, 64'(i));
            check($sformatf("drain_count_%0d", i), 64'(count), 64'(5 - i));
            step();
            check($sformatf("drain_hold_valid_%0d", i), 64'(rd_valid), 64'd0);
            check($sformatf("drain_hold_data_%0d", i), rd_data, 64'(i));
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("drained_rd_valid", 64'(rd_valid), 64'd0);

        // SKIP=3 instance: samples 10..15, only 13..15 stored
        pulse_arm();
        data_valid = 1'b1;
        for (int i = 10; i <= 15; i++) begin
            data = 64'(i);
            step();
            if (i == 11) check("skip_capturing_early", 64'(s3_capturing), 64'd0);
            if (i == 12) check("skip_capturing_on", 64'(s3_capturing), 64'd1);
        end
        data_valid = 1'b0;
        check("skip_count", 64'(s3_count), 64'd3);
        for (int i = 13; i <= 15; i++) begin
            rd_en = 1'b1;
            step();
            check($sformatf("skip_data_%0d", i), s3_rd_data, 64'(i));
        end
        rd_en = 1'b0;
        check("skip_count_drained", 64'(s3_count), 64'd0);

        // fill to DEPTH with sign-bit-set samples, overflow two
        pulse_arm();
        data_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = 64'hF000_0000_0000_0000 | 64'(i);
            step();
            if (i == 6) check("full_before", 64'(full), 64'd0);
            if (i == 7) begin
                check("full_set", 64'(full), 64'd1);
                check("full_capturing", 64'(capturing), 64'd0);
                check("full_count", 64'(count), 64'd8);
            end
        end
        data_valid = 1'b0;
        check("full_count_after_drop", 64'(count), 64'd8);
        check("full_ovf", 64'(ovf_count), 64'(exp_ovf));
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            check($sformatf("full_data_%0d", i), rd_data, 64'hF000_0000_0000_0000 | 64'(i));
        end
        rd_en = 1'b0;
        check("full_drained_count", 64'(count), 64'd0);
        check("full_held", 64'(full), 64'd1);

        // continuous write and read every cycle
        pulse_arm();
        data_valid = 1'b1;
        rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data = 64'(100 + k);
            step();
            if (k == 0) begin
                check("stream_first_valid", 64'(rd_valid), 64'd0);
                check("stream_first_count", 64'(count), 64'd1);
            end else begin
                check($sformatf("stream_valid_%0d", k), 64'(rd_valid), 64'd1);
                check($sformatf("stream_data_%0d", k), rd_data, 64'(100 + k - 1));
                check($sformatf("stream_count_%0d", k), 64'(count), 64'd1);
            end
        end
        data_valid = 1'b0;
        step();
        check("stream_last_data", rd_data, 64'd105);
        check("stream_last_count", 64'(count), 64'd0);
        step();
        rd_en = 1'b0;
        check("stream_idle_valid", 64'(rd_valid), 64'd0);

        // mid-capture arm: data_valid in arm cycle is ignored
        pulse_arm();
        data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 64'(200 + i);
            step();
        end
        check("mid_count_before", 64'(count), 64'd4);
        data = 64'hDEAD;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("mid_count_cleared", 64'(count), 64'd0);
        data = 64'h7;
        step();
        data_valid = 1'b0;
        check("mid_count_one", 64'(count), 64'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("mid_read_data", rd_data, 64'h7);

        // reset mid-capture
        data_valid = 1'b1;
        data = 64'h55;
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst2_count", 64'(count), 64'd0);
        check("rst2_capturing", 64'(capturing), 64'd0);
        check("rst2_full", 64'(full), 64'd0);
        check("rst2_rd_data", rd_data, 64'd0);
        check("rst2_rd_valid", 64'(rd_valid), 64'd0);
        data_valid = 1'b0;
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
